// File: rtl/mma_pkg.sv
// mma_pkg: shared definitions for the MMA UART command sequencer.
//   - host command / response byte codes
//   - sequencer state encoding (exported on the 4-bit debug state port)
//   - default matrix dimension limit
//   - float32 element word type
package mma_pkg;

  localparam int MAX_DIM_DEF = 8;

  // Host -> device commands
  localparam logic [7:0] CMD_RX_A = 8'h01;
  localparam logic [7:0] CMD_RX_B = 8'h02;
  localparam logic [7:0] CMD_MUL  = 8'h03;
  localparam logic [7:0] CMD_TX_R = 8'h04;

  // Device -> host responses
  localparam logic [7:0] RSP_DONE = 8'h05;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_ERR  = 8'hAA;

  typedef logic [31:0] f32_t;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_HDR     = 4'd1,
    ST_LOAD    = 4'd2,
    ST_CHECK   = 4'd3,
    ST_MUL     = 4'd4,
    ST_SEND    = 4'd5,
    ST_TX_HDR  = 4'd6,
    ST_TX_DATA = 4'd7,
    ST_ERR     = 4'd8
  } seq_state_e;

endpackage

// File: rtl/mma_seq_tx_serializer.sv
// mma_seq_tx_serializer: emits the top nbytes_i bytes of a 32-bit word as
// handshaked UART bytes, MSB first. Used for 1-byte responses (byte placed
// in word_i[31:24]) and for 4-byte header/result words.
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   start_i        one-cycle request; only honoured while idle
//   word_i         word to serialize (captured on start_i)
//   nbytes_i       number of bytes to send (1..4)
//   tx_busy_i      UART transmitter busy
//   tx_data_o      byte to transmit, held until the next byte is launched
//   tx_begin_o     one-cycle transmit request
//   done_o         one-cycle pulse once the last byte has left the UART
module mma_seq_tx_serializer
  import mma_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  f32_t       word_i,
  input  logic [2:0] nbytes_i,
  input  logic       tx_busy_i,
  output logic [7:0] tx_data_o,
  output logic       tx_begin_o,
  output logic       done_o
);

  typedef enum logic [1:0] {SER_IDLE, SER_WAIT, SER_HOLD} ser_state_e;

  ser_state_e st_q, st_d;
  f32_t       sr_q, sr_d;
  logic [2:0] left_q, left_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_begin_q, tx_begin_d;

  always_comb begin
    st_d       = st_q;
    sr_d       = sr_q;
    left_d     = left_q;
    tx_data_d  = tx_data_q;
    tx_begin_d = 1'b0;
    done_o     = 1'b0;
    case (st_q)
      SER_IDLE: begin
        if (start_i) begin
          sr_d   = word_i;
          left_d = nbytes_i;
          st_d   = SER_WAIT;
        end
      end
      // Wait for the UART to go idle; it either takes the next byte or,
      // with nothing left, the word is finished.
      SER_WAIT: begin
        if (!tx_busy_i) begin
          if (left_q == 3'd0) begin
            done_o = 1'b1;
            st_d   = SER_IDLE;
          end else begin
            tx_begin_d = 1'b1;
            tx_data_d  = sr_q[31:24];
            sr_d       = {sr_q[23:0], 8'h00};
            left_d     = left_q - 3'd1;
            st_d       = SER_HOLD;
          end
        end
      end
      // tx_begin is high this cycle; the UART raises busy at the next
      // edge, so skip one cycle before sampling tx_busy again.
      SER_HOLD: st_d = SER_WAIT;
      default:  st_d = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q       <= SER_IDLE;
      sr_q       <= '0;
      left_q     <= '0;
      tx_data_q  <= '0;
      tx_begin_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      sr_q       <= sr_d;
      left_q     <= left_d;
      tx_data_q  <= tx_data_d;
      tx_begin_q <= tx_begin_d;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_begin_o = tx_begin_q;

endmodule

// File: rtl/mma_uart_sequencer.sv
// mma_uart_sequencer: host command sequencer between the UART byte
// interface and the MMA datapath. Parses commands, unpacks big-endian
// matrix frames into the A/B memories, starts the multiply, reports DONE
// and streams the result frame back. All protocol errors answer 0xAA.
// Optional build macro: MMA_SEQ_TIMEOUT_EN adds an inter-byte timeout of
// TIMEOUT_CYCLES in HDR/LOAD; without it no counter exists.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   rx_data, rx_ready          received byte + one-cycle valid
//   tx_data, tx_begin, tx_busy UART transmit handshake
//   mem_we/sel/addr/wdata      A/B matrix memory write port
//   a_rows..b_cols             latched matrix dimensions
//   mul_start, mul_done        multiply core handshake
//   res_addr, res_data         result memory read (1-cycle latency)
//   busy, state                status / debug
module mma_uart_sequencer
  import mma_pkg::*;
#(
  parameter int MAX_DIM        = MAX_DIM_DEF,
  parameter int ADDR_W         = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_begin,
  input  logic              tx_busy,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output f32_t              mem_wdata,
  output logic [7:0]        a_rows,
  output logic [7:0]        a_cols,
  output logic [7:0]        b_rows,
  output logic [7:0]        b_cols,
  output logic              mul_start,
  input  logic              mul_done,
  output logic [ADDR_W-1:0] res_addr,
  input  f32_t              res_data,
  output logic              busy,
  output logic [3:0]        state
);

  // One extra bit so an element count of 2^ADDR_W is representable.
  localparam int CNT_W = ADDR_W + 1;

  seq_state_e        st_q, st_d;
  logic [55:0]       sr_q, sr_d;        // last 7 received bytes
  logic [2:0]        bcnt_q, bcnt_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic              sel_q, sel_d;
  logic [7:0]        a_rows_q, a_rows_d, a_cols_q, a_cols_d;
  logic [7:0]        b_rows_q, b_rows_d, b_cols_q, b_cols_d;
  logic              a_loaded_q, a_loaded_d, b_loaded_q, b_loaded_d;
  logic              r_valid_q, r_valid_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  f32_t              mem_wdata_q, mem_wdata_d;
  logic              mul_start_q, mul_start_d;
  logic [ADDR_W-1:0] res_addr_q, res_addr_d;
  logic [1:0]        ph_q, ph_d;

  logic              ser_start, ser_done;
  f32_t              ser_word;
  logic [2:0]        ser_nbytes;
  logic              timeout_hit;

  logic [63:0]       sr_nxt;
  logic [31:0]       rows_w, cols_w;
  logic [CNT_W-1:0]  idx_inc, hdr_total, tx_total;

  assign sr_nxt    = {sr_q, rx_data};
  assign rows_w    = sr_nxt[63:32];
  assign cols_w    = sr_nxt[31:0];
  assign idx_inc   = idx_q + CNT_W'(1);
  assign hdr_total = CNT_W'(rows_w[7:0]) * CNT_W'(cols_w[7:0]);
  assign tx_total  = CNT_W'(a_rows_q) * CNT_W'(b_cols_q);

  // The whole 32-bit word is range-checked, so headers above 255 can never
  // alias onto a legal 8-bit dimension.
  function automatic logic dim_ok(input logic [31:0] w);
    return (w != 32'd0) && (w <= 32'(MAX_DIM));
  endfunction

`ifdef MMA_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Counts idle cycles while a frame is being received; any byte restarts it.
  always_comb begin
    tmo_d = '0;
    if ((st_q == ST_HDR || st_q == ST_LOAD) && !rx_ready)
      tmo_d = tmo_q + TMO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end

  assign timeout_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    st_d        = st_q;
    sr_d        = sr_q;
    bcnt_d      = bcnt_q;
    idx_d       = idx_q;
    total_d     = total_q;
    sel_d       = sel_q;
    a_rows_d    = a_rows_q;
    a_cols_d    = a_cols_q;
    b_rows_d    = b_rows_q;
    b_cols_d    = b_cols_q;
    a_loaded_d  = a_loaded_q;
    b_loaded_d  = b_loaded_q;
    r_valid_d   = r_valid_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mul_start_d = 1'b0;
    res_addr_d  = res_addr_q;
    ph_d        = ph_q;
    ser_start   = 1'b0;
    ser_word    = '0;
    ser_nbytes  = 3'd1;

    case (st_q)
      ST_IDLE: begin
        if (rx_ready) begin
          case (rx_data)
            CMD_RX_A, CMD_RX_B: begin
              // The target memory is about to be overwritten, so its
              // contents are invalid until this frame completes; an
              // aborted or rejected frame therefore leaves the flag clear.
              sel_d  = (rx_data == CMD_RX_B);
              if (rx_data == CMD_RX_B) b_loaded_d = 1'b0;
              else                     a_loaded_d = 1'b0;
              bcnt_d = '0;
              st_d   = ST_HDR;
            end
            CMD_MUL:  st_d = ST_CHECK;
            CMD_TX_R: begin
              if (r_valid_q) begin
                ph_d = '0;
                st_d = ST_TX_HDR;
              end else begin
                st_d = ST_ERR;
              end
            end
            default:  st_d = ST_ERR;
          endcase
        end
      end

      ST_HDR: begin
        if (rx_ready) begin
          sr_d   = sr_nxt[55:0];
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            if (dim_ok(rows_w) && dim_ok(cols_w)) begin
              if (sel_q) begin
                b_rows_d = rows_w[7:0];
                b_cols_d = cols_w[7:0];
              end else begin
                a_rows_d = rows_w[7:0];
                a_cols_d = cols_w[7:0];
              end
              total_d = hdr_total;
              idx_d   = '0;
              bcnt_d  = '0;
              st_d    = ST_LOAD;
            end else begin
              st_d = ST_ERR;
            end
          end
        end else if (timeout_hit) begin
          st_d = ST_ERR;
        end
      end

      ST_LOAD: begin
        if (rx_ready) begin
          sr_d   = sr_nxt[55:0];
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd3) begin
            bcnt_d      = '0;
            mem_we_d    = 1'b1;
            mem_addr_d  = idx_q[ADDR_W-1:0];
            mem_wdata_d = sr_nxt[31:0];
            idx_d       = idx_inc;
            if (idx_inc == total_q) begin
              if (sel_q) b_loaded_d = 1'b1;
              else       a_loaded_d = 1'b1;
              r_valid_d = 1'b0;
              ser_start = 1'b1;
              ser_word  = {RSP_ACK, 24'h0};
              st_d      = ST_SEND;
            end
          end
        end else if (timeout_hit) begin
          st_d = ST_ERR;
        end
      end

      ST_CHECK: begin
        if (a_loaded_q && b_loaded_q && (a_cols_q == b_rows_q)) begin
          mul_start_d = 1'b1;
          st_d        = ST_MUL;
        end else begin
          st_d = ST_ERR;
        end
      end

      ST_MUL: begin
        if (mul_done) begin
          r_valid_d = 1'b1;
          ser_start = 1'b1;
          ser_word  = {RSP_DONE, 24'h0};
          st_d      = ST_SEND;
        end
      end

      ST_SEND: begin
        if (ser_done) st_d = ST_IDLE;
      end

      // ph: 0 launch rows word, 1 wait, 2 launch cols word, 3 wait
      ST_TX_HDR: begin
        ser_nbytes = 3'd4;
        case (ph_q)
          2'd0: begin
            ser_start = 1'b1;
            ser_word  = {24'h0, a_rows_q};
            ph_d      = 2'd1;
          end
          2'd2: begin
            ser_start = 1'b1;
            ser_word  = {24'h0, b_cols_q};
            ph_d      = 2'd3;
          end
          default: begin
            if (ser_done) begin
              if (ph_q == 2'd1) begin
                ph_d = 2'd2;
              end else begin
                ph_d       = 2'd0;
                idx_d      = '0;
                res_addr_d = '0;
                st_d       = ST_TX_DATA;
              end
            end
          end
        endcase
      end

      // ph: 0 res_addr settles, 1 res_data valid -> launch, 2 wait
      ST_TX_DATA: begin
        ser_nbytes = 3'd4;
        case (ph_q)
          2'd0: ph_d = 2'd1;
          2'd1: begin
            ser_start = 1'b1;
            ser_word  = res_data;
            ph_d      = 2'd2;
          end
          default: begin
            if (ser_done) begin
              if (idx_inc == tx_total) begin
                ph_d = 2'd0;
                st_d = ST_IDLE;
              end else begin
                idx_d      = idx_inc;
                res_addr_d = idx_inc[ADDR_W-1:0];
                ph_d       = 2'd0;
              end
            end
          end
        endcase
      end

      ST_ERR: begin
        ser_start = 1'b1;
        ser_word  = {RSP_ERR, 24'h0};
        st_d      = ST_SEND;
      end

      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q        <= ST_IDLE;
      sr_q        <= '0;
      bcnt_q      <= '0;
      idx_q       <= '0;
      total_q     <= '0;
      sel_q       <= 1'b0;
      a_rows_q    <= '0;
      a_cols_q    <= '0;
      b_rows_q    <= '0;
      b_cols_q    <= '0;
      a_loaded_q  <= 1'b0;
      b_loaded_q  <= 1'b0;
      r_valid_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mul_start_q <= 1'b0;
      res_addr_q  <= '0;
      ph_q        <= '0;
    end else begin
      st_q        <= st_d;
      sr_q        <= sr_d;
      bcnt_q      <= bcnt_d;
      idx_q       <= idx_d;
      total_q     <= total_d;
      sel_q       <= sel_d;
      a_rows_q    <= a_rows_d;
      a_cols_q    <= a_cols_d;
      b_rows_q    <= b_rows_d;
      b_cols_q    <= b_cols_d;
      a_loaded_q  <= a_loaded_d;
      b_loaded_q  <= b_loaded_d;
      r_valid_q   <= r_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mul_start_q <= mul_start_d;
      res_addr_q  <= res_addr_d;
      ph_q        <= ph_d;
    end
  end

  mma_seq_tx_serializer u_ser (
    .clk        (clk),
    .reset      (reset),
    .start_i    (ser_start),
    .word_i     (ser_word),
    .nbytes_i   (ser_nbytes),
    .tx_busy_i  (tx_busy),
    .tx_data_o  (tx_data),
    .tx_begin_o (tx_begin),
    .done_o     (ser_done)
  );

  assign mem_we    = mem_we_q;
  assign mem_sel   = sel_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign a_rows    = a_rows_q;
  assign a_cols    = a_cols_q;
  assign b_rows    = b_rows_q;
  assign b_cols    = b_cols_q;
  assign mul_start = mul_start_q;
  assign res_addr  = res_addr_q;
  assign busy      = (st_q != ST_IDLE);
  assign state     = st_q;

endmodule

// File: tb/tb_mma_uart_sequencer.sv
// Scoreboard bench for mma_uart_sequencer: stimulus tasks push expected
// UART bytes / memory writes into queues from a protocol-level model;
// monitors pop and compare whenever the DUT emits tx_begin or mem_we.
module tb_mma_uart_sequencer;

  localparam int MAXD = 8;
  localparam int AW   = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_begin;
  logic          tx_busy = 1'b0;
  logic          mem_we, mem_sel;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [7:0]    a_rows, a_cols, b_rows, b_cols;
  logic          mul_start;
  logic          mul_done = 1'b0;
  logic [AW-1:0] res_addr;
  logic [31:0]   res_data = 32'h0;
  logic          busy;
  logic [3:0]    state;

  mma_uart_sequencer #(.MAX_DIM(MAXD), .ADDR_W(AW), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_begin(tx_begin), .tx_busy(tx_busy),
    .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .a_rows(a_rows), .a_cols(a_cols), .b_rows(b_rows), .b_cols(b_cols),
    .mul_start(mul_start), .mul_done(mul_done), .res_addr(res_addr), .res_data(res_data),
    .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  // ---------------- scoreboard queues and protocol model ----------------
  logic [7:0]  exp_tx[$];
  logic [38:0] exp_wr[$];          // {sel, addr, data}
  bit          m_loaded[2];
  int          m_rows[2], m_cols[2];
  bit          m_rvalid = 0;
  int          exp_mul_cnt = 0;
  int          got_mul_cnt = 0;
  logic [31:0] ld_data[64];
  logic [31:0] res_mem[64];

  // ---------------- environment models ----------------
  int ub = 0;
  always @(posedge clk) begin
    if (tx_begin) begin
      tx_busy <= 1'b1;
      ub      <= $urandom_range(2, 6);
    end else if (ub > 1) begin
      ub <= ub - 1;
    end else begin
      ub      <= 0;
      tx_busy <= 1'b0;
    end
  end

  int mc = 0;
  always @(posedge clk) begin
    mul_done <= 1'b0;
    if (reset)            mc <= 0;
    else if (mul_start)   mc <= 50;
    else if (mc > 1)      mc <= mc - 1;
    else if (mc == 1) begin
      mc       <= 0;
      mul_done <= 1'b1;
    end
  end

  always @(posedge clk) res_data <= res_mem[res_addr];

  // ---------------- monitors ----------------
  logic [7:0] tx_hold = 8'h00;
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_begin) begin
        chk("tx_begin_while_busy", {63'h0, tx_busy}, 64'h0);
        if (exp_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got 0x%0h, expected no byte", tx_data);
        end else begin
          chk("tx_byte", {56'h0, tx_data}, {56'h0, exp_tx.pop_front()});
        end
        tx_hold <= tx_data;
      end else if (tx_busy) begin
        chk("tx_data_stable", {56'h0, tx_data}, {56'h0, tx_hold});
      end
      if (mem_we) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_we_unexpected: got sel=%0d addr=%0d data=0x%0h, expected none",
                   mem_sel, mem_addr, mem_wdata);
        end else begin
          chk("mem_write", {25'h0, mem_sel, mem_addr, mem_wdata}, {25'h0, exp_wr.pop_front()});
        end
      end
      if (mul_start) got_mul_cnt <= got_mul_cnt + 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    rx_data  = 8'($urandom);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]); send_byte(w[23:16]); send_byte(w[15:8]); send_byte(w[7:0]);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || exp_tx.size() != 0 || exp_wr.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_completes"}, {63'h0, (n < 5000)}, 64'h1);
    exp_tx.delete();
    exp_wr.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic do_load(input int sel, input logic [31:0] rows, input logic [31:0] cols,
                         input bit rnd);
    bit ok;
    int n;
    logic sb;
    sb = (sel == 1);
    ok = (rows >= 1) && (rows <= MAXD) && (cols >= 1) && (cols <= MAXD);
    n  = ok ? int'(rows) * int'(cols) : 0;
    m_loaded[sel] = 0;
    for (int i = 0; i < n; i++) begin
      if (rnd) ld_data[i] = $urandom;
      exp_wr.push_back({sb, 6'(i), ld_data[i]});
    end
    if (ok) begin
      exp_tx.push_back(8'h06);
      m_rows[sel] = int'(rows);
      m_cols[sel] = int'(cols);
      m_rvalid    = 0;
      m_loaded[sel] = 1;
    end else begin
      exp_tx.push_back(8'hAA);
    end
    send_byte(sb ? 8'h02 : 8'h01);
    send_word(rows);
    send_word(cols);
    for (int i = 0; i < n; i++) send_word(ld_data[i]);
    wait_idle("load");
  endtask

  // Result contents are whatever the core model "computes"; with rnd=0 the
  // caller has already placed them in res_mem.
  task automatic do_mul(input bit rnd);
    if (m_loaded[0] && m_loaded[1] && m_cols[0] == m_rows[1]) begin
      if (rnd) for (int i = 0; i < 64; i++) res_mem[i] = $urandom;
      exp_mul_cnt++;
      exp_tx.push_back(8'h05);
      m_rvalid = 1;
    end else begin
      exp_tx.push_back(8'hAA);
    end
    send_byte(8'h03);
    wait_idle("mul");
  endtask

  task automatic do_txr();
    logic [31:0] w;
    if (m_rvalid) begin
      w = 32'(m_rows[0]);
      for (int k = 3; k >= 0; k--) exp_tx.push_back(w[k*8 +: 8]);
      w = 32'(m_cols[1]);
      for (int k = 3; k >= 0; k--) exp_tx.push_back(w[k*8 +: 8]);
      for (int i = 0; i < m_rows[0] * m_cols[1]; i++) begin
        w = res_mem[i];
        for (int k = 3; k >= 0; k--) exp_tx.push_back(w[k*8 +: 8]);
      end
    end else begin
      exp_tx.push_back(8'hAA);
    end
    send_byte(8'h04);
    wait_idle("txr");
  endtask

  task automatic do_bad(input logic [7:0] b);
    exp_tx.push_back(8'hAA);
    send_byte(b);
    wait_idle("badcmd");
  endtask

  function automatic logic [31:0] rnd_dim();
    logic [31:0] bad[4];
    bad[0] = 32'd0; bad[1] = 32'd9; bad[2] = 32'd256; bad[3] = 32'h0001_0002;
    if ($urandom_range(0, 7) == 0) return bad[$urandom_range(0, 3)];
    return 32'($urandom_range(1, MAXD));
  endfunction

  initial begin
    m_loaded[0] = 0; m_loaded[1] = 0;
    m_rows[0] = 0; m_rows[1] = 0; m_cols[0] = 0; m_cols[1] = 0;
    for (int i = 0; i < 64; i++) res_mem[i] = 32'h0;

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {56'h0, tx_begin, mem_we, mul_start, busy, state}, 64'h0);
    chk("reset_dims", {32'h0, a_rows, a_cols, b_rows, b_cols}, 64'h0);
    chk("reset_data", {19'h0, mem_sel, mem_addr, res_addr, tx_data, mem_wdata}, 64'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // planned 2x2 multiply flow
    ld_data[0] = 32'h3f800000; ld_data[1] = 32'h40000000;
    ld_data[2] = 32'h40400000; ld_data[3] = 32'h40800000;
    do_load(0, 2, 2, 0);
    chk("a_dims", {48'h0, a_rows, a_cols}, {48'h0, 8'd2, 8'd2});
    ld_data[0] = 32'h40a00000; ld_data[1] = 32'h40c00000;
    ld_data[2] = 32'h40e00000; ld_data[3] = 32'h41000000;
    do_load(1, 2, 2, 0);
    res_mem[0] = 32'h41980000; res_mem[1] = 32'h41b00000;
    res_mem[2] = 32'h422c0000; res_mem[3] = 32'h42480000;
    do_mul(0);
    do_txr();

    // error paths
    do_bad(8'h07);
    do_bad(8'h00);
    do_load(1, 9, 2, 1);            // B rejected -> only A loaded
    do_mul(1);
    do_load(0, 0, 2, 1);
    do_load(0, 2, 32'h100, 1);
    do_load(0, 2, 3, 1);
    do_load(1, 2, 2, 1);
    do_mul(1);                      // 2x3 * 2x2 mismatch
    do_txr();                       // loads cleared r_valid
    do_load(0, 8, 8, 1);            // largest frame, addr up to 63
    do_load(1, 8, 1, 1);
    do_mul(1);
    do_txr();

    // reset after the 10th byte of a load
    send_byte(8'h01); send_word(32'd2); send_word(32'd2); send_byte(8'h3f);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midload_reset_state", {60'h0, state}, 64'h0);
    chk("midload_reset_busy", {63'h0, busy}, 64'h0);
    reset = 1'b0;
    m_loaded[0] = 0; m_loaded[1] = 0; m_rvalid = 0;
    m_rows[0] = 0; m_rows[1] = 0; m_cols[0] = 0; m_cols[1] = 0;
    repeat (20) @(negedge clk);     // any stray ACK is flagged as unexpected
    do_load(0, 2, 2, 1);
    do_txr();

`ifdef MMA_SEQ_TIMEOUT_EN
    do_load(1, 2, 2, 1);
    exp_tx.push_back(8'hAA);
    send_byte(8'h01); send_word(32'd2); send_word(32'd2);
    send_byte(8'h11); send_byte(8'h22);
    m_loaded[0] = 0;
    wait_idle("timeout");
    do_mul(1);                      // A must now be unloaded
`endif

    // randomized operation mix
    for (int it = 0; it < 25; it++) begin
      int op;
      logic [31:0] r, c;
      op = $urandom_range(0, 5);
      case (op)
        0, 1: begin
          r = rnd_dim();
          c = rnd_dim();
          if (op == 1 && m_cols[0] != 0 && $urandom_range(0, 1) == 1) r = 32'(m_cols[0]);
          do_load(op, r, c, 1);
        end
        2: do_mul(1);
        3: do_txr();
        4: do_bad(($urandom_range(0, 1) == 1) ? 8'($urandom_range(5, 255)) : 8'h00);
        default: begin
          do_mul(1);
          do_txr();
        end
      endcase
    end

    repeat (5) @(negedge clk);
    chk("mul_start_count", 64'(got_mul_cnt), 64'(exp_mul_cnt));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mma_uart_sequencer.md
Name: mma_uart_sequencer

Overview:
- Command sequencer between the UART byte interface and the MMA datapath (matrix memories plus the multiply core).
- Parses host command bytes, unpacks big-endian matrix frames into the A/B memories, and starts the multiply.
- Signals completion with DONE and streams the result frame back over UART.
- Owns all protocol error handling; the multiply core never sees malformed input.

Parameters:
- MAX_DIM, 8, maximum rows/cols accepted per matrix
- ADDR_W, 6, element address width; must satisfy 2^ADDR_W >= MAX_DIM*MAX_DIM
- TIMEOUT_CYCLES, 1000000, inter-byte timeout during frame reception (optional feature only)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- rx_data  in  8  received UART byte
- rx_ready  in  1  one-cycle pulse; rx_data valid
- tx_data  out  8  byte to transmit
- tx_begin  out  1  one-cycle transmit request
- tx_busy  in  1  UART transmitter busy
- mem_we  out  1  matrix memory write strobe
- mem_sel  out  1  0=A, 1=B
- mem_addr  out  ADDR_W  row-major element address
- mem_wdata  out  32  float32 element
- a_rows, a_cols, b_rows, b_cols  out  8 each  latched dimensions
- mul_start  out  1  one-cycle multiply start
- mul_done  in  1  one-cycle pulse from core
- res_addr  out  ADDR_W  result read address
- res_data  in  32  result element; valid 1 cycle after res_addr
- busy  out  1  high in every state except IDLE
- state  out  4  current state (debug)

Behaviour:
- Reset: state=IDLE, all outputs 0, dims 0, a_loaded/b_loaded/r_valid cleared. A reset mid-operation aborts immediately, with no partial ACK.
- Command bytes: 0x01 RX_A, 0x02 RX_B, 0x03 MULTIPLY, 0x04 TX_R. Responses: 0x05 DONE, 0x06 ACK, 0xAA ERR.
- IDLE on rx_ready:
  - 0x01/0x02 → HDR, with mem_sel set.
  - 0x03 → CHECK.
  - 0x04 → TX_HDR if r_valid, else ERR.
  - Any other byte → ERR.
- HDR: collects 8 bytes as a 32-bit rows word then a 32-bit cols word, MSB first. A value of 0, or a value > MAX_DIM, gives ERR once the 8th byte arrives. Otherwise dims latch → LOAD.
- LOAD:
  - Collects 4 bytes per element, MSB first.
  - On the 4th byte: mem_we pulses for exactly 1 cycle, mem_addr = element index, starting at 0 and incrementing.
  - After rows*cols elements: set the matching loaded flag, clear r_valid, go to SEND with ACK.
- CHECK: requires a_loaded & b_loaded & (a_cols == b_rows).
  - Pass: mul_start pulses 1 cycle → MUL.
  - Fail: ERR.
- MUL: waits for mul_done, then sets r_valid and goes to SEND with DONE.
- TX_HDR/TX_DATA: send a_rows as a 32-bit word, then b_cols as a 32-bit word, then a_rows*b_cols elements. All words are MSB first, elements row-major. res_addr is issued one cycle before its bytes are needed.
- SEND handshake:
  - tx_begin is asserted only when tx_busy=0.
  - The block then holds one cycle, then waits for tx_busy=0 before the next byte.
  - tx_data is stable from tx_begin until tx_busy falls.
- ERR: sends 0xAA via SEND → IDLE. The offending load's loaded flag is cleared.
- rx_ready pulses arriving in CHECK/MUL/SEND/TX states are discarded.
- rx_ready coinciding with the final LOAD byte: the byte is consumed by LOAD. It is not treated as a command.
- The byte counter wraps only on frame completion. A 32-bit header above 255 always errors; the 8-bit dimension outputs are never truncated silently.

Optional Feature:
- Macro: MMA_SEQ_TIMEOUT_EN.
- Defined: a counter resets on each rx_ready in HDR/LOAD. Reaching TIMEOUT_CYCLES → ERR (0xAA), frame discarded, loaded flag cleared.
- Undefined: HDR/LOAD wait indefinitely; no counter logic is synthesised.

Decomposition:
- Shared package mma_pkg holds:
  - command/response byte constants
  - state encoding
  - MAX_DIM default
  - the float32 word type
- Natural sub-module: mma_seq_tx_serializer. It converts a 32-bit word into 4 handshaked UART bytes, MSB first, and is reused for header and data.

Test Plan:
- Load A: 0x01, rows=2, cols=2, then 3f800000 40000000 40400000 40800000 → four mem_we pulses, sel=0, addr 0..3 with those words; tx 0x06.
- Load B (5,6,7,8f), then 0x03 → one mul_start. Model mul_done after 50 cycles → tx 0x05.
- Then 0x04 with a res_data model → tx 00000002 00000002 41980000 41b00000 422c0000 42480000 (19,22,43,50).
- Error paths:
  - 0x07 → 0xAA.
  - 0x03 with only A loaded → 0xAA.
  - A 2x3 and B 2x2, then 0x03 → 0xAA.
  - Header rows=0 or rows=9 → 0xAA, with no mem_we.
- Reset asserted after the 10th byte of a load → state=IDLE next cycle, no ACK. A fresh load then succeeds with addr starting at 0.
- With MMA_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=100: stall 101 cycles mid-LOAD → 0xAA, a_loaded=0.
